// File: rtl/bfly_pkg.sv
// Shared constants and the saturation helper for the radix-2 butterfly pipeline.
package bfly_pkg;

  localparam int DW_DEF   = 8;
  localparam int FRAC_DEF = 7;

  // Clamp a sign-extended value to the signed range of a dw-bit word (dw <= 31).
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int dw);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (dw - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/fft_butterfly_pipe_cmul_q.sv
// Registered complex multiply p = w*b with a FRAC-bit output shift.
// BFLY_ROUND_EN selects round-half-up instead of floor for that shift.
module cmul_q
  import bfly_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [DW-1:0] w_re,
  input  logic signed [DW-1:0] w_im,
  output logic signed [DW+1:0] p_re,
  output logic signed [DW+1:0] p_im
);

  localparam int PW = 2 * DW + 1;
`ifdef BFLY_ROUND_EN
  localparam logic signed [PW-1:0] HALF = PW'(1 << (FRAC - 1));
`else
  localparam logic signed [PW-1:0] HALF = PW'(0);
`endif

  logic signed [PW-1:0] full_re;
  logic signed [PW-1:0] full_im;
  logic signed [DW+1:0] next_re;
  logic signed [DW+1:0] next_im;

  always_comb begin
    full_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
    full_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
    next_re = (DW+2)'((full_re + HALF) >>> FRAC);
    next_im = (DW+2)'((full_im + HALF) >>> FRAC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_re <= '0;
      p_im <= '0;
    end else if (en) begin
      p_re <= next_re;
      p_im <= next_im;
    end
  end

endmodule

// File: rtl/fft_butterfly_pipe.sv
// Three-stage radix-2 butterfly x = a + w*b, y = a - w*b with saturation and a sticky ovf flag.
// Optional macro BFLY_ROUND_EN makes both the FRAC shift and the SCALE halving round half-up.
module fft_butterfly_pipe
  import bfly_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int SCALE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [DW-1:0] w_re,
  input  logic signed [DW-1:0] w_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] x_re,
  output logic signed [DW-1:0] x_im,
  output logic signed [DW-1:0] y_re,
  output logic signed [DW-1:0] y_im,
  output logic                 ovf,
  input  logic                 clr_ovf
);

  localparam int SW = DW + 3;
`ifdef BFLY_ROUND_EN
  localparam int SC_RND = 1;
`else
  localparam int SC_RND = 0;
`endif

  logic                 en;
  logic                 s1_valid;
  logic                 s2_valid;
  logic signed [DW-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im, s1_w_re, s1_w_im;
  logic signed [DW-1:0] s2_a_re, s2_a_im;
  logic signed [DW+1:0] p_re, p_im;
  logic signed [SW-1:0] sum [4];
  logic signed [DW-1:0] sat [4];
  logic [3:0]           hit;

  // A single enable stalls every stage, so bubbles keep their slots.
  assign en       = out_ready || !out_valid;
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a_re  <= '0;
      s1_a_im  <= '0;
      s1_b_re  <= '0;
      s1_b_im  <= '0;
      s1_w_re  <= '0;
      s1_w_im  <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_a_re  <= a_re;
      s1_a_im  <= a_im;
      s1_b_re  <= b_re;
      s1_b_im  <= b_im;
      s1_w_re  <= w_re;
      s1_w_im  <= w_im;
    end
  end

  cmul_q #(.DW(DW), .FRAC(FRAC)) u_cmul (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .b_re  (s1_b_re),
    .b_im  (s1_b_im),
    .w_re  (s1_w_re),
    .w_im  (s1_w_im),
    .p_re  (p_re),
    .p_im  (p_im)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_a_re  <= '0;
      s2_a_im  <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_a_re  <= s1_a_re;
      s2_a_im  <= s1_a_im;
    end
  end

  always_comb begin : sum_sat
    logic signed [SW-1:0] sc;
    logic signed [31:0]   wide;
    logic signed [31:0]   clip;
    sc   = '0;
    wide = '0;
    clip = '0;
    hit  = '0;
    sum[0] = SW'(s2_a_re) + SW'(p_re);
    sum[1] = SW'(s2_a_im) + SW'(p_im);
    sum[2] = SW'(s2_a_re) - SW'(p_re);
    sum[3] = SW'(s2_a_im) - SW'(p_im);
    for (int i = 0; i < 4; i++) begin
      sc     = (SCALE != 0) ? ((sum[i] + SW'(SC_RND)) >>> 1) : sum[i];
      wide   = 32'(sc);
      clip   = saturate(wide, DW);
      sat[i] = DW'(clip);
      hit[i] = (clip != wide);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      x_re      <= '0;
      x_im      <= '0;
      y_re      <= '0;
      y_im      <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      x_re      <= sat[0];
      x_im      <= sat[1];
      y_re      <= sat[2];
      y_im      <= sat[3];
    end
  end

  // Only real sets raise ovf; a new saturation beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (en && s2_valid && (|hit)) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Self-checking bench: SCALE=0 and SCALE=1 instances share stimulus and are checked
// every cycle against an arithmetic model of the butterfly, plus literal spot checks.
module tb_fft_butterfly_pipe;

  localparam int DW = 8;
  localparam int FRAC = 7;

  typedef struct packed {
    logic signed [7:0] xr;
    logic signed [7:0] xi;
    logic signed [7:0] yr;
    logic signed [7:0] yi;
    logic              sat;
  } res_t;

  logic clk = 1'b0;
  logic reset, in_valid, out_ready, clr_ovf;
  logic signed [7:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic in_ready0, out_valid0, ovf0, in_ready1, out_valid1, ovf1;
  logic signed [7:0] x0_re, x0_im, y0_re, y0_im, x1_re, x1_im, y1_re, y1_im;

  int checks = 0;
  int failures = 0;
  res_t q0[$];
  res_t q1[$];
  logic pv = 1'b0, pr = 1'b0, prev_reset = 1'b1, prev_clr = 1'b0;
  logic m_ovf0 = 1'b0, m_ovf1 = 1'b0;
  logic [31:0] sv0 = 32'd0, sv1 = 32'd0;

  always #5 clk = ~clk;

  fft_butterfly_pipe #(.DW(DW), .FRAC(FRAC), .SCALE(0)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid0), .out_ready(out_ready),
    .x_re(x0_re), .x_im(x0_im), .y_re(y0_re), .y_im(y0_im), .ovf(ovf0), .clr_ovf(clr_ovf));

  fft_butterfly_pipe #(.DW(DW), .FRAC(FRAC), .SCALE(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid1), .out_ready(out_ready),
    .x_re(x1_re), .x_im(x1_im), .y_re(y1_re), .y_im(y1_im), .ovf(ovf1), .clr_ovf(clr_ovf));

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // floor(n / 2^k), or round half-up when the rounding build is selected
  function automatic int fl(input int n, input int k);
    int d, q;
    d = 1 << k;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int shr(input int n, input int k);
`ifdef BFLY_ROUND_EN
    return fl(n + (1 << (k - 1)), k);
`else
    return fl(n, k);
`endif
  endfunction

  function automatic res_t model(input int ar, ai, br, bi, wr, wi, input bit scale);
    int pr_, pi_;
    int v[4];
    res_t r;
    pr_ = shr(br * wr - bi * wi, FRAC);
    pi_ = shr(br * wi + bi * wr, FRAC);
    v = '{ar + pr_, ai + pi_, ar - pr_, ai - pi_};
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (scale) v[i] = shr(v[i], 1);
      if (v[i] > 127) begin v[i] = 127; r.sat = 1'b1; end
      else if (v[i] < -128) begin v[i] = -128; r.sat = 1'b1; end
    end
    r.xr = 8'(v[0]); r.xi = 8'(v[1]); r.yr = 8'(v[2]); r.yi = 8'(v[3]);
    return r;
  endfunction

  // Per-cycle comparison against the model queues
  always @(negedge clk) begin
    logic held, newly;
    res_t e0, e1;
    logic [31:0] cur0, cur1;
    cur0 = {x0_re, x0_im, y0_re, y0_im};
    cur1 = {x1_re, x1_im, y1_re, y1_im};
    e0 = '0;
    e1 = '0;
    newly = 1'b0;
    if (prev_reset) begin
      check("reset_valid", int'(out_valid0 | out_valid1), 0);
      check("reset_ovf", int'(ovf0 | ovf1), 0);
      check("reset_data", int'(cur0 | cur1), 0);
      m_ovf0 = 1'b0;
      m_ovf1 = 1'b0;
    end else begin
      held = pv && !pr;
      check("valid_pair", int'(out_valid1), int'(out_valid0));
      if (out_valid0) begin
        if (q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=valid required=no_result_pending");
        end else begin
          e0 = q0[0];
          e1 = q1[0];
          newly = !held;
          check("x0_re", x0_re, e0.xr); check("x0_im", x0_im, e0.xi);
          check("y0_re", y0_re, e0.yr); check("y0_im", y0_im, e0.yi);
          check("x1_re", x1_re, e1.xr); check("x1_im", x1_im, e1.xi);
          check("y1_re", y1_re, e1.yr); check("y1_im", y1_im, e1.yi);
        end
        if (held) begin
          check("hold_stable0", int'(cur0), int'(sv0));
          check("hold_stable1", int'(cur1), int'(sv1));
        end
      end
      m_ovf0 = (newly && e0.sat) ? 1'b1 : (prev_clr ? 1'b0 : m_ovf0);
      m_ovf1 = (newly && e1.sat) ? 1'b1 : (prev_clr ? 1'b0 : m_ovf1);
      check("ovf0", int'(ovf0), int'(m_ovf0));
      check("ovf1", int'(ovf1), int'(m_ovf1));
    end
    check("in_ready0", int'(in_ready0), int'(out_ready || !out_valid0));
    check("in_ready1", int'(in_ready1), int'(out_ready || !out_valid1));
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (out_valid0 && out_ready && q0.size() > 0) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (in_valid && in_ready0) begin
        q0.push_back(model(a_re, a_im, b_re, b_im, w_re, w_im, 1'b0));
        q1.push_back(model(a_re, a_im, b_re, b_im, w_re, w_im, 1'b1));
      end
    end
    pv = out_valid0;
    pr = out_ready;
    prev_reset = reset;
    prev_clr = clr_ovf;
    sv0 = cur0;
    sv1 = cur1;
  end

  // One set with out_ready high; returns just after the third edge after acceptance.
  task automatic drive_one(input int ar, ai, br, bi, wr, wi);
    @(posedge clk); #1;
    in_valid = 1'b1;
    a_re = 8'(ar); a_im = 8'(ai); b_re = 8'(br); b_im = 8'(bi); w_re = 8'(wr); w_im = 8'(wi);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("lat_early", int'(out_valid0), 0);
    @(posedge clk); #1;
    check("lat_n3", int'(out_valid0), 1);
  endtask

  task automatic stream(input int n, input int budget, input int stall_at, input int stall_len,
                        input int vprob, input int rprob, input int cprob);
    int sent;
    logic acc;
    sent = 0;
    for (int c = 0; c < budget && sent < n; c++) begin
      out_ready = (c >= stall_at && c < stall_at + stall_len) ? 1'b0 : ($urandom_range(99) < rprob);
      clr_ovf = ($urandom_range(99) < cprob);
      if (!in_valid && $urandom_range(99) < vprob) begin
        in_valid = 1'b1;
        a_re = 8'($urandom); a_im = 8'($urandom); b_re = 8'($urandom);
        b_im = 8'($urandom); w_re = 8'($urandom); w_im = 8'($urandom);
      end
      @(negedge clk);
      acc = in_valid && in_ready0;
      if (acc) sent++;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    clr_ovf = 1'b0;
    check("stream_sent", sent, n);
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
    check("drain_empty", q0.size(), 0);
  endtask

  initial begin
    res_t r;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("in_ready_after_reset", int'(in_ready0), 1);

    r = model(10, 20, 4, -6, -128, 0, 1'b0);
    check("model_s0", int'({r.xr, r.xi, r.yr, r.yi}), int'({8'sd6, 8'sd26, 8'sd14, 8'sd14}));
    r = model(10, 20, 4, -6, -128, 0, 1'b1);
    check("model_s1", int'({r.xr, r.xi, r.yr, r.yi}), int'({8'sd3, 8'sd13, 8'sd7, 8'sd7}));

    drive_one(10, 20, 4, -6, -128, 0);
    check("b1_x0_re", x0_re, 6);  check("b1_x0_im", x0_im, 26);
    check("b1_y0_re", y0_re, 14); check("b1_y0_im", y0_im, 14);
    check("b1_x1_re", x1_re, 3);  check("b1_x1_im", x1_im, 13);
    check("b1_y1_re", y1_re, 7);  check("b1_y1_im", y1_im, 7);
    check("b1_ovf", int'(ovf0), 0);

    drive_one(127, 0, 127, 0, -128, 0);
    check("sat_x0_re", x0_re, 0);  check("sat_x0_im", x0_im, 0);
    check("sat_y0_re", y0_re, 127); check("sat_y0_im", y0_im, 0);
    check("sat_ovf_set", int'(ovf0), 1);
    check("sat_ovf1_clear", int'(ovf1), 0);
    repeat (2) @(posedge clk);
    #1 check("sat_ovf_sticky", int'(ovf0), 1);
    clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
    check("sat_ovf_cleared", int'(ovf0), 0);

    drive_one(0, 0, 3, 0, 64, 0);
`ifdef BFLY_ROUND_EN
    check("rnd_x_re", x0_re, 2);
    check("rnd_y_re", y0_re, -2);
`else
    check("trunc_x_re", x0_re, 1);
    check("trunc_y_re", y0_re, -1);
`endif
    drain();

    // Six back-to-back sets with a five-cycle downstream stall once results appear
    stream(6, 40, 3, 5, 100, 100, 0);
    drain();

    // Reset with two sets in flight
    @(posedge clk); #1;
    in_valid = 1'b1; a_re = 8'sd50; b_re = 8'sd100; w_re = 8'sd100;
    @(posedge clk); #1;
    a_re = -8'sd50;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst2_in_ready", int'(in_ready0), 1);
    check("rst2_out_valid", int'(out_valid0), 0);
    drive_one(10, 20, 4, -6, -128, 0);
    check("rst2_x0_re", x0_re, 6);
    check("rst2_y0_im", y0_im, 14);
    drain();

    stream(300, 3000, -1, 0, 70, 70, 15);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_butterfly_pipe.md
FFT_BUTTERFLY_PIPE -- requirements
Module: fft_butterfly_pipe

Interface
REQ-001 Parameter DW, default 8: signed two's-complement width of every data and twiddle operand.
REQ-002 Parameter FRAC, default 7: fractional bits of twiddle operands, Q(DW-1-FRAC).FRAC; legal range 1..DW-1.
REQ-003 Parameter SCALE, default 1: 1 = both outputs arithmetically halved; 0 = no scaling.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  input operand set valid.
REQ-007 in_ready  out  1  block accepts the operand set this cycle.
REQ-008 a_re, a_im, b_re, b_im  in  DW each  butterfly data inputs a and b.
REQ-009 w_re, w_im  in  DW each  twiddle factor w.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 x_re, x_im, y_re, y_im  out  DW each  results x = a + w*b, y = a - w*b.
REQ-013 ovf  out  1  sticky saturation flag.
REQ-014 clr_ovf  in  1  clears ovf.

Function
REQ-015 Input is accepted on a cycle with in_valid && in_ready.
REQ-016 Global enable en = out_ready || !out_valid; in_ready SHALL equal en; all pipeline stages advance only when en=1.
REQ-017 Latency: a set accepted at cycle N SHALL appear with out_valid=1 at cycle N+3 when en stays high.
REQ-018 Stage 1 registers the operands; stage 2 registers the complex product p = w*b; stage 3 registers the saturated sums.
REQ-019 Product: full-precision p_re = b_re*w_re - b_im*w_im and p_im = b_re*w_im + b_im*w_re, each 2*DW+1 bits, then shifted right by FRAC and kept at DW+2 bits.
REQ-020 Without rounding, the shift is arithmetic truncation (floor).
REQ-021 Sums a+p and a-p are formed at DW+3 bits; with SCALE=1 each is arithmetically shifted right by 1 (floor).
REQ-022 Each of the four results SHALL saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-023 Any component that saturates on an advancing cycle SHALL set ovf on the next edge.
REQ-024 ovf remains set until clr_ovf=1 or reset.
REQ-025 If clr_ovf and a new saturation coincide, ovf SHALL end the cycle at 1 (set wins).
REQ-026 Bubbles (invalid slots) propagate through the pipeline unchanged; they are not collapsed.
REQ-027 While out_valid=1 and out_ready=0, the outputs SHALL hold stable and in_ready SHALL be 0.

Reset
REQ-028 During reset, all stage valid bits, out_valid, ovf and all data outputs SHALL be 0.
REQ-029 Reset mid-operation discards all in-flight sets; in_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-030 With macro BFLY_ROUND_EN defined, the FRAC shift of REQ-019 SHALL round half-up (add 2^(FRAC-1) before shifting), and the SCALE shift SHALL also round half-up.
REQ-031 Without BFLY_ROUND_EN, both shifts truncate as in REQ-020 and REQ-021; latency is identical in both builds.

Structure
REQ-032 Package bfly_pkg SHALL hold the default DW/FRAC constants and a saturate function (input width to DW).
REQ-033 The complex multiply with its FRAC shift SHALL live in sub-module cmul_q (one register stage, enable input), instantiated once.

Verification (DW=8, FRAC=7)
REQ-034 SCALE=0; a=(10,20), b=(4,-6), w=(-128,0) -> x=(6,26), y=(14,14) at cycle N+3; ovf=0.
REQ-035 SCALE=1, same inputs as REQ-034 -> x=(3,13), y=(7,7).
REQ-036 SCALE=0; a=(127,0), b=(127,0), w=(-128,0) -> x=(0,0), y=(127,0) saturated; ovf=1 next cycle, stays 1 until a clr_ovf pulse.
REQ-037 SCALE=0; a=(0,0), b=(3,0), w=(64,0) -> x_re=1, y_re=-1 without BFLY_ROUND_EN; x_re=2, y_re=-2 with it.
REQ-038 Stream 6 back-to-back sets and hold out_ready=0 for 5 cycles mid-stream -> outputs stable during the hold, in_ready=0, no loss or duplication, results in order.
REQ-039 Assert reset with 2 sets in flight -> out_valid=0 and no stale result after reset; next accepted set emerges at N+3.
